// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition-code encodings and default datapath widths.
package cpu_pkg;

   localparam int unsigned PC_W_DEF   = 8;
   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned OFF_W_DEF  = 8;

   typedef enum logic [2:0] {
      COND_ALWAYS = 3'b000,
      COND_EQ     = 3'b001,
      COND_NE     = 3'b010,
      COND_GT     = 3'b011,
      COND_LT     = 3'b100,
      COND_GE     = 3'b101,
      COND_LE     = 3'b110,
      COND_NEVER  = 3'b111
   } cond_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator: decodes jumpSignal against the stored Z/N flags.
module branch_cond_eval
   import cpu_pkg::*;
(
   input  logic [2:0] jumpSignal,
   input  logic       flag_z,
   input  logic       flag_n,
   output logic       cond,
   output logic       cond_illegal
);

   always_comb begin
      cond         = 1'b0;
      cond_illegal = 1'b0;
      unique case (cond_e'(jumpSignal))
         COND_ALWAYS: cond = 1'b1;
         COND_EQ:     cond = flag_z;
         COND_NE:     cond = ~flag_z;
         COND_GT:     cond = ~flag_z & ~flag_n;
         COND_LT:     cond = flag_n;
         COND_GE:     cond = ~flag_n;
         COND_LE:     cond = flag_z | flag_n;
         COND_NEVER:  cond_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/pc_branch_unit.sv
// PC register, compare flags and next-PC selection for the multicycle core.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
module pc_branch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned     PC_W     = PC_W_DEF,
   parameter int unsigned     DATA_W   = DATA_W_DEF,
   parameter int unsigned     OFF_W    = OFF_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              pcReadsignal,
   input  logic              pcWrite,
   input  logic              changePc,
   input  logic              jumpCondCheck,
   input  logic [2:0]        jumpSignal,
   input  logic              compareSignal,
   input  logic [DATA_W-1:0] opA,
   input  logic [DATA_W-1:0] opB,
   input  logic [OFF_W-1:0]  offset,
   output logic [PC_W-1:0]   pc,
   output logic [PC_W-1:0]   fetch_addr,
   output logic              flag_z,
   output logic              flag_n,
   output logic              branch_taken,
   output logic              cond_err
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0]       br_taken_cnt,
   output logic [15:0]       br_not_cnt
`endif
);

   localparam int unsigned EXT_W = (PC_W > OFF_W) ? PC_W : OFF_W;

   logic [PC_W-1:0]  pcQ, pcNext, fetchQ;
   logic             flagZQ, flagNQ, condErrQ;
   logic             cond, condIllegal;
   logic             condCommit;
   logic [EXT_W-1:0] offExt;

   branch_cond_eval u_cond (
      .jumpSignal   (jumpSignal),
      .flag_z       (flagZQ),
      .flag_n       (flagNQ),
      .cond         (cond),
      .cond_illegal (condIllegal)
   );

   assign offExt       = EXT_W'($signed(offset));
   assign branch_taken = changePc & (jumpCondCheck ? cond : 1'b1);
   assign condCommit   = pcWrite & changePc & jumpCondCheck;

   always_comb begin
      pcNext = pcQ + PC_W'(1);
      if (branch_taken) begin
         if (jumpCondCheck) pcNext = pcQ + offExt[PC_W-1:0];
         else               pcNext = opA[PC_W-1:0];
      end
   end

   // Branch resolution reads the pre-edge flags even when a compare lands on the same edge.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         pcQ      <= RESET_PC;
         fetchQ   <= RESET_PC;
         flagZQ   <= 1'b0;
         flagNQ   <= 1'b0;
         condErrQ <= 1'b0;
      end else begin
         if (pcReadsignal) fetchQ <= pcQ;
         if (compareSignal) begin
            flagZQ <= (opA == opB);
            flagNQ <= ($signed(opA) < $signed(opB));
         end
         if (pcWrite) pcQ <= pcNext;
         if (condCommit && condIllegal) condErrQ <= 1'b1;
      end
   end

   assign pc         = pcQ;
   assign fetch_addr = fetchQ;
   assign flag_z     = flagZQ;
   assign flag_n     = flagNQ;
   assign cond_err   = condErrQ;

`ifdef BRANCH_STATS_EN
   logic [15:0] takenCntQ, notCntQ;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         takenCntQ <= '0;
         notCntQ   <= '0;
      end else if (condCommit) begin
         if (branch_taken) begin
            if (takenCntQ != 16'hFFFF) takenCntQ <= takenCntQ + 16'd1;
         end else begin
            if (notCntQ != 16'hFFFF) notCntQ <= notCntQ + 16'd1;
         end
      end
   end

   assign br_taken_cnt = takenCntQ;
   assign br_not_cnt   = notCntQ;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit; stats checks build when BRANCH_STATS_EN is set.
module tb_pc_branch_unit;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic        pcReadsignal, pcWrite, changePc, jumpCondCheck, compareSignal;
   logic [2:0]  jumpSignal;
   logic [15:0] opA, opB;
   logic [7:0]  offset;
   logic [7:0]  pc, fetch_addr;
   logic        flag_z, flag_n, branch_taken, cond_err;
`ifdef BRANCH_STATS_EN
   logic [15:0] br_taken_cnt, br_not_cnt;
`endif

   int checks = 0;
   int failures = 0;
   int expTaken = 0;
   int expNot = 0;

   always #5 Clock = ~Clock;

   pc_branch_unit dut (
      .Clock         (Clock),
      .Reset_n       (Reset_n),
      .pcReadsignal  (pcReadsignal),
      .pcWrite       (pcWrite),
      .changePc      (changePc),
      .jumpCondCheck (jumpCondCheck),
      .jumpSignal    (jumpSignal),
      .compareSignal (compareSignal),
      .opA           (opA),
      .opB           (opB),
      .offset        (offset),
      .pc            (pc),
      .fetch_addr    (fetch_addr),
      .flag_z        (flag_z),
      .flag_n        (flag_n),
      .branch_taken  (branch_taken),
      .cond_err      (cond_err)
`ifdef BRANCH_STATS_EN
      ,
      .br_taken_cnt  (br_taken_cnt),
      .br_not_cnt    (br_not_cnt)
`endif
   );

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic idle;
      pcReadsignal = 0; pcWrite = 0; changePc = 0; jumpCondCheck = 0;
      compareSignal = 0; jumpSignal = 3'b000; opA = '0; opB = '0; offset = '0;
   endtask

   task automatic setPc(input logic [7:0] v);
      idle();
      changePc = 1; pcWrite = 1; opA = {8'h00, v};
      tick();
      idle();
   endtask

   task automatic doCompare(input logic [15:0] a, input logic [15:0] b);
      idle();
      compareSignal = 1; opA = a; opB = b;
      tick();
      idle();
   endtask

   task automatic test_reset;
      idle();
      Reset_n = 0;
      #12 Reset_n = 1;
      tick();
      checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_pc got=%h exp=00", pc); end
      checks++; if (fetch_addr !== 8'h00) begin failures++; $display("FAIL reset_fetch got=%h exp=00", fetch_addr); end
      checks++; if ({flag_z, flag_n, cond_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {flag_z, flag_n, cond_err}); end
      setPc(8'h37);
      pcReadsignal = 1; tick(); idle();
      doCompare(16'd5, 16'd5);
      checks++; if (pc !== 8'h37 || fetch_addr !== 8'h37 || flag_z !== 1'b1) begin failures++; $display("FAIL pre_reset_state pc=%h fetch=%h z=%b exp 37 37 1", pc, fetch_addr, flag_z); end
      // Reset mid-cycle with a register jump pending; nothing must survive.
      changePc = 1; pcWrite = 1; opA = 16'h0080;
      #2 Reset_n = 0;
      #1;
      checks++; if (pc !== 8'h00 || fetch_addr !== 8'h00) begin failures++; $display("FAIL async_reset_pc pc=%h fetch=%h exp 00 00", pc, fetch_addr); end
      checks++; if ({flag_z, flag_n, cond_err} !== 3'b000) begin failures++; $display("FAIL async_reset_flags got=%b exp=000", {flag_z, flag_n, cond_err}); end
      idle();
      #2 Reset_n = 1;
      tick();
      checks++; if (pc !== 8'h00) begin failures++; $display("FAIL reset_discard_pending got=%h exp=00", pc); end
   endtask

   task automatic test_wrap;
      logic [7:0] exp [3];
      exp[0] = 8'hFF; exp[1] = 8'h00; exp[2] = 8'h01;
      setPc(8'hFE);
      checks++; if (pc !== 8'hFE) begin failures++; $display("FAIL wrap_start got=%h exp=fe", pc); end
      for (int i = 0; i < 3; i++) begin
         idle(); pcWrite = 1; tick();
         checks++; if (pc !== exp[i]) begin failures++; $display("FAIL wrap_step%0d got=%h exp=%h", i, pc, exp[i]); end
      end
      idle();
   endtask

   task automatic test_fetch;
      setPc(8'h40);
      pcReadsignal = 1; tick(); idle();
      checks++; if (fetch_addr !== 8'h40) begin failures++; $display("FAIL fetch_capture got=%h exp=40", fetch_addr); end
      pcWrite = 1; tick(); idle();
      checks++; if (pc !== 8'h41 || fetch_addr !== 8'h40) begin failures++; $display("FAIL fetch_hold pc=%h fetch=%h exp 41 40", pc, fetch_addr); end
      pcReadsignal = 1; pcWrite = 1; tick(); idle();
      checks++; if (pc !== 8'h42 || fetch_addr !== 8'h41) begin failures++; $display("FAIL fetch_with_write pc=%h fetch=%h exp 42 41", pc, fetch_addr); end
   endtask

   task automatic test_hold;
      setPc(8'h60);
      changePc = 1; jumpCondCheck = 0; opA = 16'h0099; #1;
      checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL hold_taken_comb got=%b exp=1", branch_taken); end
      tick();
      checks++; if (pc !== 8'h60) begin failures++; $display("FAIL hold_regjump got=%h exp=60", pc); end
      jumpCondCheck = 1; jumpSignal = 3'b000; offset = 8'h10; tick(); idle();
      checks++; if (pc !== 8'h60) begin failures++; $display("FAIL hold_condjump got=%h exp=60", pc); end
   endtask

   task automatic condJump(input logic [2:0] code, input logic [7:0] off, input logic expTk);
      idle();
      changePc = 1; jumpCondCheck = 1; jumpSignal = code; offset = off; pcWrite = 1;
      #1;
      checks++; if (branch_taken !== expTk) begin failures++; $display("FAIL branch_taken code=%b got=%b exp=%b", code, branch_taken, expTk); end
      if (expTk) expTaken++; else expNot++;
      tick();
      idle();
   endtask

   task automatic test_cond_eq;
      setPc(8'd10);
      doCompare(16'd5, 16'd5);
      checks++; if (flag_z !== 1'b1 || flag_n !== 1'b0) begin failures++; $display("FAIL eq_flags z=%b n=%b exp 1 0", flag_z, flag_n); end
      condJump(3'b001, 8'hFD, 1'b1);
      checks++; if (pc !== 8'd7) begin failures++; $display("FAIL je_taken got=%0d exp=7", pc); end
      setPc(8'd10);
      doCompare(16'd5, 16'd6);
      condJump(3'b001, 8'hFD, 1'b0);
      checks++; if (pc !== 8'd11) begin failures++; $display("FAIL je_not_taken got=%0d exp=11", pc); end
   endtask

   task automatic test_signed;
      doCompare(16'hFFFF, 16'h0001);
      checks++; if (flag_n !== 1'b1 || flag_z !== 1'b0) begin failures++; $display("FAIL signed_flags z=%b n=%b exp 0 1", flag_z, flag_n); end
      setPc(8'd20);
      condJump(3'b101, 8'h04, 1'b0);
      checks++; if (pc !== 8'd21) begin failures++; $display("FAIL jge got=%0d exp=21", pc); end
      setPc(8'd20);
      condJump(3'b110, 8'h04, 1'b1);
      checks++; if (pc !== 8'd24) begin failures++; $display("FAIL jle got=%0d exp=24", pc); end
   endtask

   task automatic test_cond_table;
      logic [6:0] takeLt, takeEq;
      takeLt = 7'b1010101;   // flags z=0 n=1
      takeEq = 7'b1100011;   // flags z=1 n=0
      doCompare(16'h0002, 16'h0009);
      for (int i = 0; i < 7; i++) begin
         setPc(8'd50);
         condJump(3'(i), 8'h02, takeLt[i]);
         checks++; if (pc !== (takeLt[i] ? 8'd52 : 8'd51)) begin failures++; $display("FAIL table_lt code=%0d got=%0d", i, pc); end
      end
      doCompare(16'h8000, 16'h8000);
      for (int i = 0; i < 7; i++) begin
         setPc(8'd50);
         condJump(3'(i), 8'h02, takeEq[i]);
         checks++; if (pc !== (takeEq[i] ? 8'd52 : 8'd51)) begin failures++; $display("FAIL table_eq code=%0d got=%0d", i, pc); end
      end
   endtask

   task automatic test_regjump;
      setPc(8'h00);
      changePc = 1; jumpCondCheck = 0; opA = 16'h1234; pcWrite = 1; tick(); idle();
      checks++; if (pc !== 8'h34) begin failures++; $display("FAIL regjump got=%h exp=34", pc); end
      checks++; if (cond_err !== 1'b0) begin failures++; $display("FAIL cond_err_early got=%b exp=0", cond_err); end
      condJump(3'b111, 8'h10, 1'b0);
      checks++; if (pc !== 8'h35 || cond_err !== 1'b1) begin failures++; $display("FAIL never_commit pc=%h err=%b exp 35 1", pc, cond_err); end
      pcWrite = 1; tick(); idle();
      checks++; if (cond_err !== 1'b1) begin failures++; $display("FAIL cond_err_sticky got=%b exp=1", cond_err); end
   endtask

   task automatic test_back_to_back;
      doCompare(16'd3, 16'd3);
      setPc(8'd100);
      compareSignal = 1; opA = 16'd3; opB = 16'd4;
      changePc = 1; jumpCondCheck = 1; jumpSignal = 3'b001; offset = 8'h05; pcWrite = 1;
      expTaken++;
      tick(); idle();
      checks++; if (pc !== 8'd105) begin failures++; $display("FAIL b2b_old_flags got=%0d exp=105", pc); end
      checks++; if (flag_z !== 1'b0 || flag_n !== 1'b1) begin failures++; $display("FAIL b2b_new_flags z=%b n=%b exp 0 1", flag_z, flag_n); end
      checks++; if (cond_err !== 1'b1) begin failures++; $display("FAIL b2b_cond_err got=%b exp=1", cond_err); end
   endtask

   task automatic test_stats;
`ifdef BRANCH_STATS_EN
      checks++; if (br_taken_cnt !== 16'(expTaken)) begin failures++; $display("FAIL stats_taken got=%0d exp=%0d", br_taken_cnt, expTaken); end
      checks++; if (br_not_cnt !== 16'(expNot)) begin failures++; $display("FAIL stats_not got=%0d exp=%0d", br_not_cnt, expNot); end
`endif
      #2 Reset_n = 0;
      #1;
      checks++; if (cond_err !== 1'b0 || pc !== 8'h00) begin failures++; $display("FAIL final_reset err=%b pc=%h exp 0 00", cond_err, pc); end
`ifdef BRANCH_STATS_EN
      checks++; if (br_taken_cnt !== 16'd0 || br_not_cnt !== 16'd0) begin failures++; $display("FAIL stats_reset taken=%0d not=%0d exp 0 0", br_taken_cnt, br_not_cnt); end
`endif
      #2 Reset_n = 1;
      tick();
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_fetch();
      test_hold();
      test_cond_eq();
      test_signed();
      test_cond_table();
      test_regjump();
      test_back_to_back();
      test_stats();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter and branch-resolution stage fed directly by the multicycle control unit.
- Holds the PC, latches compare flags on compareSignal, and evaluates the condition selected by jumpSignal/jumpCondCheck.
- Commits the next PC (PC+1, PC-relative target, or register target) on pcWrite.
- Presents a stable fetch address to instruction memory.

Parameters:
PC_W, 8, PC / instruction-address width
DATA_W, 16, register operand width for compares and register jumps
OFF_W, 8, signed branch-offset width from the instruction word
RESET_PC, 0, PC value after reset

Ports:
Clock  in  1  rising-edge clock
Reset_n  in  1  asynchronous active-low reset
pcReadsignal  in  1  fetch cycle; capture the fetch address
pcWrite  in  1  commit next PC this edge
changePc  in  1  registered "PC-changing instruction" from control
jumpCondCheck  in  1  1 = conditional PC-relative jump; 0 = register jump
jumpSignal  in  3  condition code
compareSignal  in  1  latch flags from opA/opB this edge
opA  in  DATA_W  first compare operand / register-jump target
opB  in  DATA_W  second compare operand
offset  in  OFF_W  signed branch offset
pc  out  PC_W  current PC
fetch_addr  out  PC_W  address held for instruction memory
flag_z  out  1  last compare equal
flag_n  out  1  last compare signed less-than
branch_taken  out  1  combinational, current condition true and changePc=1
cond_err  out  1  sticky, jumpSignal=111 seen on a committing conditional jump

Behaviour:
- Reset (async, Reset_n=0):
  - pc=RESET_PC, fetch_addr=RESET_PC.
  - flag_z=0, flag_n=0, cond_err=0.
  - Counters (if enabled) = 0.
  - Release is synchronous to the next edge, with no glitch.
- Fetch: on an edge with pcReadsignal=1, fetch_addr<=pc. The value then holds until the next pcReadsignal.
- Compare: on an edge with compareSignal=1:
  - flag_z <= (opA==opB).
  - flag_n <= ($signed(opA) < $signed(opB)).
  - Otherwise the flags hold.
- Conditions (jumpCondCheck=1), encoded by jumpSignal:
  - 000 always
  - 001 Z
  - 010 !Z
  - 011 !Z & !N (greater)
  - 100 N
  - 101 !N
  - 110 Z|N
  - 111 never; sets cond_err if pcWrite=1
- branch_taken is computed combinationally from the current (pre-edge) flags:
  - changePc & (jumpCondCheck ? cond : 1).
- Next-PC selection on an edge with pcWrite=1:
  - branch_taken & jumpCondCheck: pc <= pc + sign-extended offset, modulo 2^PC_W.
  - branch_taken & !jumpCondCheck: pc <= opA[PC_W-1:0].
  - Otherwise: pc <= pc+1, wrapping from 2^PC_W-1 to 0.
- Latency: one edge from pcWrite to the new pc. fetch_addr updates on the following pcReadsignal edge.
- Simultaneous compareSignal & pcWrite: the branch uses the old flags, and the new flags are still stored.
- Simultaneous pcReadsignal & pcWrite: fetch_addr gets the pre-edge pc. This combination does not occur in normal sequencing but is defined.
- Reset mid-instruction: everything returns to reset values immediately, and any pending changePc effect is discarded.
- pcWrite=0: pc holds regardless of changePc/jumpSignal.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined:
  - Adds outputs br_taken_cnt (16) and br_not_cnt (16).
  - On each pcWrite edge with changePc=1 and jumpCondCheck=1, the taken or not-taken counter increments.
  - Both counters saturate at 16'hFFFF.
  - Both are cleared by reset.
- When undefined: these ports and registers do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - The condition-code constants (COND_ALWAYS, COND_EQ, COND_NE, COND_GT, COND_LT, COND_GE, COND_LE, COND_NEVER) as a 3-bit type.
  - The default PC_W, DATA_W and OFF_W.
- One sub-module, branch_cond_eval: purely combinational, taking (jumpSignal, flag_z, flag_n) and producing (cond, cond_illegal).
- The PC register, flags and counters stay in the top module.

Test Plan:
- Reset at pc=8'h37 → pc=0, fetch_addr=0, flags=0, cond_err=0 immediately, before any clock edge.
- Three sequential pcWrite with changePc=0 from pc=8'hFE → 8'hFF, 8'h00, 8'h01 (wrap).
- compare opA=5, opB=5 then JE (jumpSignal=001, jumpCondCheck=1, changePc=1, offset=-3) at pc=10 → pc=7. Same setup with opA=5, opB=6 → pc=11.
- Signed compare opA=16'hFFFF (-1), opB=1 → flag_n=1, flag_z=0. JGE (101) at pc=20 → pc=21. JLE (110) offset=+4 → pc=24.
- Register jump: changePc=1, jumpCondCheck=0, opA=16'h1234, pcWrite → pc=8'h34. jumpSignal=111 conditional commit → pc+1 and cond_err=1 (sticky until reset).
- compareSignal & pcWrite on the same edge, with old flag_z=1, new compare unequal, and JE → branch taken. flag_z=0 afterwards. With BRANCH_STATS_EN, br_taken_cnt increments by 1.
